s1423_cmp_pipe: RTL and testbench

- Registered operand-select and carry-compare stage for the s1423 n55 datapath, using the same mux-and-carry-chain function as that combinational cone.
- Takes two candidate operands, selects one with a mode bit, and adds it to a reference word through a carry chain.
- Emits a gated compare flag: flag = gate AND NOT(carry_out XOR msb_ref).
- Wraps that function in a 2-stage valid/ready pipeline with a saturating hit counter, so upstream test-pattern sources can stream vectors and downstream checkers can consume results.

---
 rtl/s1423_pkg.sv | 11 +
 rtl/s1423_carry_core.sv | 17 +
 rtl/s1423_cmp_pipe.sv | 62 ++++++
 tb/tb_s1423_cmp_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/s1423_pkg.sv
// s1423_pkg: shared widths and the S1 payload type for the s1423 compare pipe
package s1423_pkg;
    localparam int W_DEF = 5;
    localparam int CW_DEF = 8;
    typedef struct packed {
        logic [W_DEF-1:0] op;
        logic [W_DEF-1:0] ref_w;
        logic msb_ref;
        logic gate;
    } cmp_vec_t;
endpackage

// File: rtl/s1423_carry_core.sv
// s1423_carry_core: combinational n55 cone, add through the carry chain and gate the compare flag
module s1423_carry_core
    import s1423_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] op,
    input  logic [W-1:0] ref_w,
    input  logic         msb_ref,
    input  logic         gate,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         flag
);
    assign {carry, sum} = {1'b0, op} + {1'b0, ref_w};
    assign flag = gate & ~(carry ^ msb_ref);
endmodule

// File: rtl/s1423_cmp_pipe.sv
// s1423_cmp_pipe: 2-stage valid/ready operand-select and carry-compare pipe with saturating hit counter
module s1423_cmp_pipe
    import s1423_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sel,
    input  logic [W-1:0]  opa,
    input  logic [W-1:0]  opb,
    input  logic [W-1:0]  ref_w,
    input  logic          msb_ref,
    input  logic          gate,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_flag,
    output logic          out_carry,
    output logic [W-1:0]  out_sum,
    input  logic          cnt_clr,
    output logic [CW-1:0] hit_count,
    output logic          hit_sat
);
    cmp_vec_t s1;
    logic s1_valid, cap, load, hit, c_carry, c_flag;
    logic [W-1:0] c_sum;
    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign cap = in_valid & in_ready;
    assign load = s1_valid & (~out_valid | out_ready);
    assign hit = out_valid & out_ready & out_flag;
    s1423_carry_core #(.W(W)) u_core (
        .op     (s1.op),
        .ref_w  (s1.ref_w),
        .msb_ref(s1.msb_ref),
        .gate   (s1.gate),
        .sum    (c_sum),
        .carry  (c_carry),
        .flag   (c_flag)
    );
    always_ff @(posedge CK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_flag  <= 1'b0;
            out_carry <= 1'b0;
            out_sum   <= '0;
            hit_count <= '0;
            hit_sat   <= 1'b0;
        end else begin
            if (cap) s1 <= {sel ? opb : opa, ref_w, msb_ref, gate};
            s1_valid  <= cap | (s1_valid & ~load);
            out_valid <= load | (out_valid & ~out_ready);
            if (load) {out_sum, out_carry, out_flag} <= {c_sum, c_carry, c_flag};
            // clear beats a same-cycle hit; sat flags on the step into all-ones
            hit_count <= cnt_clr ? '0 : (hit & ~&hit_count) ? hit_count + 1'b1 : hit_count;
            hit_sat   <= ~cnt_clr & (hit_sat | (hit & (hit_count == {{(CW-1){1'b1}}, 1'b0})));
        end
    end
endmodule

// File: tb/tb_s1423_cmp_pipe.sv
// tb_s1423_cmp_pipe: scoreboard bench with directed cases and random streaming against an arithmetic model
module tb_s1423_cmp_pipe;
    logic CK = 1'b0;
    logic RST, in_valid, in_ready, sel, msb_ref, gate, out_ready, cnt_clr;
    logic [4:0] opa, opb, ref_w;
    logic out_valid, out_flag, out_carry, hit_sat;
    logic [4:0] out_sum;
    logic [7:0] hit_count;
    logic rdy2, ov2, of2, oc2, hs2;
    logic [4:0] os2;
    logic [1:0] hc2;

    typedef struct {
        logic [4:0] sum;
        logic carry;
        logic flag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int compared = 0, mismatched = 0;
    int exp_cnt, exp_cnt2;
    bit exp_sat, exp_sat2, mon_hit, held;
    logic [6:0] held_v;
    logic [4:0] bp_sum;
    int sat_exp[5] = '{1, 2, 3, 3, 3};

    always #5 CK = ~CK;

    s1423_cmp_pipe #(.W(5), .CW(8)) dut (
        .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .opa(opa), .opb(opb), .ref_w(ref_w), .msb_ref(msb_ref), .gate(gate),
        .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag),
        .out_carry(out_carry), .out_sum(out_sum), .cnt_clr(cnt_clr),
        .hit_count(hit_count), .hit_sat(hit_sat)
    );

    s1423_cmp_pipe #(.W(5), .CW(2)) dut2 (
        .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(rdy2), .sel(sel),
        .opa(opa), .opb(opb), .ref_w(ref_w), .msb_ref(msb_ref), .gate(gate),
        .out_valid(ov2), .out_ready(out_ready), .out_flag(of2),
        .out_carry(oc2), .out_sum(os2), .cnt_clr(cnt_clr),
        .hit_count(hc2), .hit_sat(hs2)
    );

    function automatic exp_t model(int op, int r, bit m, bit g);
        int s = op + r;
        model.sum = 5'(s % 32);
        model.carry = s >= 32;
        model.flag = g && (model.carry == m);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic set_vec(bit v, bit s, logic [4:0] a, logic [4:0] b, logic [4:0] r, bit m, bit g);
        in_valid = v; sel = s; opa = a; opb = b; ref_w = r; msb_ref = m; gate = g;
    endtask

    task automatic wait_accept();
        int k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
        end
        step();
    endtask

    // expected result recorded at the moment a vector is handed over
    always @(negedge CK)
        if (!RST && in_valid && in_ready) q.push_back(model(sel ? opb : opa, ref_w, msb_ref, gate));

    always @(negedge CK) begin
        if (RST) begin
            q.delete();
            exp_cnt = 0; exp_cnt2 = 0; exp_sat = 0; exp_sat2 = 0; held = 0;
        end else begin
            chk("hit_count", hit_count, exp_cnt);
            chk("hit_sat", hit_sat, exp_sat);
            chk("hit_count_cw2", hc2, exp_cnt2);
            chk("hit_sat_cw2", hs2, exp_sat2);
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_sum, out_carry, out_flag}, held_v);
            end
            held = out_valid && !out_ready;
            held_v = {out_sum, out_carry, out_flag};
            mon_hit = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_out: result sum=%0h with no vector pending", out_sum);
                end else begin
                    e = q.pop_front();
                    chk("out_sum", out_sum, e.sum);
                    chk("out_carry", out_carry, e.carry);
                    chk("out_flag", out_flag, e.flag);
                    mon_hit = e.flag;
                end
            end
            if (cnt_clr) begin
                exp_cnt = 0; exp_cnt2 = 0; exp_sat = 0; exp_sat2 = 0;
            end else if (mon_hit) begin
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt == 255) exp_sat = 1;
                if (exp_cnt2 < 3) exp_cnt2++;
                if (exp_cnt2 == 3) exp_sat2 = 1;
            end
        end
    end

    initial begin
        RST = 1; cnt_clr = 0; out_ready = 0;
        set_vec(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        RST = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_count", hit_count, 0);

        out_ready = 1;
        set_vec(1, 0, 5'h10, 5'h00, 5'h10, 1, 1);
        step();
        in_valid = 0;
        step();
        chk("basic_valid", out_valid, 1);
        chk("basic_sum", out_sum, 0);
        chk("basic_carry", out_carry, 1);
        chk("basic_flag", out_flag, 1);
        step();
        chk("basic_count", hit_count, 1);

        set_vec(1, 1, 5'h1F, 5'h03, 5'h04, 0, 1);
        step();
        gate = 0;
        step();
        in_valid = 0;
        chk("sel_sum", out_sum, 5'h07);
        chk("sel_carry", out_carry, 0);
        chk("sel_flag", out_flag, 1);
        step();
        chk("gate0_flag", out_flag, 0);
        chk("gate0_sum", out_sum, 5'h07);
        chk("sel_count", hit_count, 2);
        step();
        chk("gate0_count", hit_count, 2);

        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_vec(1, i[0], 5'(i * 7 + 1), 5'(i * 5 + 2), 5'(i * 9 + 20), i[1], 1);
            if (i == 2) begin
                chk("bp_in_ready_low", in_ready, 0);
                bp_sum = out_sum;
                step();
                chk("bp_hold_sum", out_sum, bp_sum);
                chk("bp_in_ready_stall", in_ready, 0);
                step();
                out_ready = 1;
            end
            wait_accept();
        end
        in_valid = 0;
        repeat (4) step();
        chk("bp_drained", q.size(), 0);

        RST = 1;
        step();
        RST = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_vec(1, 0, 0, 0, 0, 0, 1);
            step();
            in_valid = 0;
            step();
            step();
            chk("sat_count_cw2", hc2, sat_exp[i]);
            chk("sat_flag_cw2", hs2, i >= 2);
        end
        set_vec(1, 0, 0, 0, 0, 0, 1);
        step();
        in_valid = 0;
        step();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        chk("clr_count_cw2", hc2, 0);
        chk("clr_sat_cw2", hs2, 0);
        chk("clr_count", hit_count, 0);

        out_ready = 0;
        set_vec(1, 0, 5'h01, 5'h02, 5'h1F, 1, 1);
        step();
        opa = 5'h07;
        step();
        in_valid = 0;
        RST = 1;
        step();
        RST = 0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_count", hit_count, 0);
        out_ready = 1;
        repeat (3) begin
            step();
            chk("midrst_no_stale", out_valid, 0);
        end

        for (int n = 0; n < 13000; n++) begin
            set_vec($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                    5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            cnt_clr = $urandom_range(0, 63) == 0;
            step();
        end
        in_valid = 0; out_ready = 1; cnt_clr = 0;
        repeat (5) step();
        chk("final_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
